// File: rtl/mem_bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mem_bridge_pkg
// Shared definitions for the core-to-memory bus bridge:
//   bridge_state_e   - FSM state encoding (also exported on the debug port)
//   DEFAULT_TIMEOUT  - default abort threshold in wait cycles
//   DEFAULT_ERR_DATA - default read data returned on an aborted read
//   ctr_width()      - width of the wait counter for a given TIMEOUT
// ---------------------------------------------------------------------------
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } bridge_state_e;

  localparam int unsigned DEFAULT_TIMEOUT  = 255;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0000;

  // The counter must be able to hold TIMEOUT itself (it saturates there).
  function automatic int unsigned ctr_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_bus_bridge_if
// External memory bus between the bridge (master) and the memory (slave).
//
// Handshake semantics:
//   - mem_req is the request valid; mem_gnt is its ready. A request is
//     accepted on the rising edge where mem_req && mem_gnt. While mem_req is
//     high, mem_we / mem_addr / mem_wdata are held stable by the master.
//   - For reads, mem_rvalid qualifies mem_rdata for one cycle; the master is
//     always ready for it once the request has been granted. mem_gnt outside
//     a request and mem_rvalid outside a pending read are ignored.
//
// Signals:
//   mem_req    master->slave  request valid
//   mem_we     master->slave  request is a write
//   mem_addr   master->slave  30-bit word address
//   mem_wdata  master->slave  write data
//   mem_gnt    slave->master  request accepted
//   mem_rvalid slave->master  read data valid
//   mem_rdata  slave->master  read data
// ---------------------------------------------------------------------------
interface mem_bus_bridge_if;

  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_bus_bridge_timeout_ctr.sv
// ---------------------------------------------------------------------------
// bus_timeout_ctr
// Wait-cycle counter used to abort stalled bus accesses.
//
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-low reset
//   clear_i   in   zero the counter (wins over enable)
//   enable_i  in   count this cycle
//   count_o   out  current count (cycles already spent in the wait state)
//   expired_o out  high on the TIMEOUT-th enabled cycle since the last clear
//
// The count is 0 in the first cycle after a clear, so expired_o asserts in
// the cycle where the count would reach TIMEOUT at the next edge.
// ---------------------------------------------------------------------------
module bus_timeout_ctr
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CW      = ctr_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic [CW-1:0] count_o,
  output logic          expired_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = enable_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// mem_bus_bridge
// Bridges single-cycle core load/store requests onto a req/gnt/rvalid
// memory bus, stalling the core while an access is outstanding and aborting
// accesses that wait longer than TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT   wait cycles allowed in REQ or WAIT_R before abort
//   ERR_DATA  load data returned for an aborted read
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   reset        in   asynchronous active-low reset
//   core_addr    in   byte address (bits [1:0] ignored)
//   core_wdata   in   store data
//   core_we      in   store request (wins when core_re is also high)
//   core_re      in   load request
//   core_rdata   out  last captured load data (or ERR_DATA after abort)
//   core_stall   out  combinational core freeze
//   bus_err      out  one-cycle pulse (in DONE) after an aborted access
//   mem          if   memory bus, master side
//   dbg_state_o  out  current FSM state
//   dbg_wait_cnt_o out current wait counter value
//
// Build option: define MEM_BRIDGE_WBUF_EN to post stores through a one-entry
// write buffer so a store presented in IDLE does not stall the core.
// ---------------------------------------------------------------------------
module mem_bus_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    core_addr,
  input  logic [31:0]                    core_wdata,
  input  logic                           core_we,
  input  logic                           core_re,
  output logic [31:0]                    core_rdata,
  output logic                           core_stall,
  output logic                           bus_err,
  mem_bus_bridge_if.master               mem,
  output bridge_state_e                  dbg_state_o,
  output logic [ctr_width(TIMEOUT)-1:0]  dbg_wait_cnt_o
);

  localparam int unsigned CW = ctr_width(TIMEOUT);

  bridge_state_e state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [29:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   core_rdata_q;
  logic          bus_err_q;

  logic          access;
  logic          ctr_clear;
  logic          ctr_enable;
  logic          ctr_expired;
  logic [CW-1:0] ctr_count;

  // Byte offset within the word is not forwarded to the word-addressed bus.
  logic [1:0]    core_addr_unused;
  assign core_addr_unused = core_addr[1:0];

  assign access = core_we | core_re;

`ifdef MEM_BRIDGE_WBUF_EN
  // Set while a posted store occupies the buffer; the FSM is then busy with
  // that store and the core runs ahead until it presents another access.
  logic wbuf_q;
`endif

  // ---------------------------------------------------------------------
  // Wait counter: cleared on every entry into REQ or WAIT_R, counting
  // while in either state.
  // ---------------------------------------------------------------------
  always_comb begin
    ctr_clear = 1'b0;
    case (state_q)
      ST_IDLE: ctr_clear = access;
      ST_REQ:  ctr_clear = mem.mem_gnt && !mem_we_q;
      default: ctr_clear = 1'b0;
    endcase
  end

  assign ctr_enable = (state_q == ST_REQ) || (state_q == ST_WAIT_R);

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout_ctr (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (ctr_clear),
    .enable_i  (ctr_enable),
    .count_o   (ctr_count),
    .expired_o (ctr_expired)
  );

  // ---------------------------------------------------------------------
  // Core stall.
  // ---------------------------------------------------------------------
  always_comb begin
    core_stall = 1'b0;
`ifdef MEM_BRIDGE_WBUF_EN
    if (wbuf_q) begin
      // A posted store is in flight: anything new waits until IDLE.
      core_stall = access;
    end else begin
      case (state_q)
        // A store (including store+load, where the load is dropped) posts.
        ST_IDLE:   core_stall = core_re & ~core_we;
        ST_REQ:    core_stall = 1'b1;
        ST_WAIT_R: core_stall = 1'b1;
        default:   core_stall = 1'b0;
      endcase
    end
`else
    case (state_q)
      ST_IDLE:   core_stall = access;
      ST_REQ:    core_stall = 1'b1;
      ST_WAIT_R: core_stall = 1'b1;
      default:   core_stall = 1'b0;
    endcase
`endif
  end

  // ---------------------------------------------------------------------
  // Access FSM with registered bus outputs.
  // A grant or rvalid on the timeout cycle is checked first, so it wins.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      bus_err_q    <= 1'b0;
`ifdef MEM_BRIDGE_WBUF_EN
      wbuf_q       <= 1'b0;
`endif
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            state_q     <= ST_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= core_we;
            mem_addr_q  <= core_addr[31:2];
            mem_wdata_q <= core_wdata;
`ifdef MEM_BRIDGE_WBUF_EN
            wbuf_q      <= core_we;
`endif
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_we_q ? ST_DONE : ST_WAIT_R;
          end else if (ctr_expired) begin
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (!mem_we_q) begin
              core_rdata_q <= ERR_DATA;
            end
            state_q   <= ST_DONE;
          end
        end
        ST_WAIT_R: begin
          if (mem.mem_rvalid) begin
            core_rdata_q <= mem.mem_rdata;
            state_q      <= ST_DONE;
          end else if (ctr_expired) begin
            core_rdata_q <= ERR_DATA;
            bus_err_q    <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
`ifdef MEM_BRIDGE_WBUF_EN
          wbuf_q  <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign core_rdata     = core_rdata_q;
  assign bus_err        = bus_err_q;
  assign dbg_state_o    = state_q;
  assign dbg_wait_cnt_o = ctr_count;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_bridge
// Directed bench for mem_bus_bridge (TIMEOUT=4, ERR_DATA=32'hDEAD_BEEF).
// Stimulus pushes expected bus requests and completions into queues; a
// monitor pops and compares whenever the DUT presents a request or reaches
// DONE. A memory responder drives gnt/rvalid with per-access delays.
// ---------------------------------------------------------------------------
module tb_mem_bus_bridge;
  import mem_bridge_pkg::*;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
`ifdef MEM_BRIDGE_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   core_addr  = '0;
  logic [31:0]   core_wdata = '0;
  logic          core_we    = 1'b0;
  logic          core_re    = 1'b0;
  logic [31:0]   core_rdata;
  logic          core_stall;
  logic          bus_err;
  bridge_state_e dbg_state;
  logic [2:0]    dbg_cnt;

  mem_bus_bridge_if m();

  mem_bus_bridge #(
    .TIMEOUT  (4),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_we        (core_we),
    .core_re        (core_re),
    .core_rdata     (core_rdata),
    .core_stall     (core_stall),
    .bus_err        (bus_err),
    .mem            (m.master),
    .dbg_state_o    (dbg_state),
    .dbg_wait_cnt_o (dbg_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [62:0] exp_mem_q[$];   // {we, word addr, wdata}
  logic [32:0] exp_done_q[$];  // {bus_err, core_rdata}
  int req_cycles = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          gnt_delay = 0;  // -1: never grant
  int          rv_delay  = 0;  // -1: never return data
  logic [31:0] rv_data   = '0;
  bit          inject_rv = 1'b0;

  initial begin
    int req_cnt;
    int rv_cnt;
    req_cnt = 0;
    rv_cnt  = 0;
    m.mem_gnt    = 1'b0;
    m.mem_rvalid = 1'b0;
    m.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      m.mem_gnt    = 1'b0;
      m.mem_rvalid = 1'b0;
      m.mem_rdata  = '0;
      if (!reset) begin
        req_cnt = 0;
        rv_cnt  = 0;
      end else begin
        if (inject_rv) begin
          m.mem_rvalid = 1'b1;
          m.mem_rdata  = 32'hFFFF_FFFF;
          inject_rv    = 1'b0;
        end
        if (dbg_state == ST_WAIT_R) begin
          if (rv_delay >= 0 && rv_cnt == rv_delay) begin
            m.mem_rvalid = 1'b1;
            m.mem_rdata  = rv_data;
          end
          rv_cnt++;
        end else begin
          rv_cnt = 0;
        end
        if (m.mem_req) begin
          if (gnt_delay >= 0 && req_cnt == gnt_delay) begin
            m.mem_gnt = 1'b1;
            req_cnt   = 0;
          end else begin
            req_cnt++;
          end
        end else begin
          req_cnt = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        prev_req;
    logic [62:0] em;
    logic [32:0] ed;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (m.mem_req) begin
        req_cycles++;
        if (exp_mem_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mem_req_unexpected: got mem_req=1 expected no request");
        end else begin
          em = exp_mem_q[0];
          check("mem_we", m.mem_we, em[62]);
          check("mem_addr", m.mem_addr, em[61:32]);
          check("mem_wdata", m.mem_wdata, em[31:0]);
        end
      end
      if (prev_req && !m.mem_req && exp_mem_q.size() > 0) void'(exp_mem_q.pop_front());
      prev_req = m.mem_req;
      if (bus_err) begin
        err_pulses++;
        check("bus_err_in_done", dbg_state, ST_DONE);
      end
      if (dbg_state == ST_DONE) begin
        if (exp_done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done_unexpected: got DONE expected no completion");
        end else begin
          ed = exp_done_q.pop_front();
          check("done_bus_err", bus_err, ed[32]);
          check("done_rdata", core_rdata, ed[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present an access, hold it while stalled, release it one edge after
  // the stall drops. Returns the number of stalled cycles.
  task automatic do_access(input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gd, input int rd,
                           input logic [31:0] rdat, output int stall_cyc);
    bit done;
    gnt_delay  = gd;
    rv_delay   = rd;
    rv_data    = rdat;
    core_we    = we;
    core_re    = re;
    core_addr  = addr;
    core_wdata = wdata;
    stall_cyc  = 0;
    done       = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (core_stall) stall_cyc++;
      else done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL access_timeout: stall still high after 64 cycles");
    end
    @(posedge clk);
    #1;
    core_we = 1'b0;
    core_re = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 64 && !idle; i++) begin
      @(negedge clk);
      if (dbg_state == ST_IDLE) idle = 1'b1;
    end
    if (!idle) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: FSM not back in IDLE after 64 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input string name, input logic we, input logic re,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int gd, input int rd, input logic [31:0] rdat,
                            input int exp_stall, input int exp_req,
                            input logic exp_err, input logic [31:0] exp_rdata);
    int base;
    int st;
    base = req_cycles;
    exp_mem_q.push_back({we, addr[31:2], wdata});
    exp_done_q.push_back({exp_err, exp_rdata});
    do_access(we, re, addr, wdata, gd, rd, rdat, st);
    wait_idle();
    check({name, "_stall"}, st, exp_stall);
    check({name, "_req_cycles"}, req_cycles - base, exp_req);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int st;
    int base;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_mem_req", m.mem_req, 1'b0);
    check("rst_mem_we", m.mem_we, 1'b0);
    check("rst_mem_addr", m.mem_addr, 30'h0);
    check("rst_mem_wdata", m.mem_wdata, 32'h0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_stall", core_stall, 1'b0);
    check("rst_wait_cnt", dbg_cnt, 3'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Read 0x10: gnt first REQ cycle, rvalid two cycles after gnt.
    run_access("rd_basic", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 0, 1, 32'hCAFE_0001,
               4, 1, 1'b0, 32'hCAFE_0001);
    // Write to 0x20 with grant held off 3 cycles (grant lands on timeout cycle).
    run_access("wr_gnt_late", 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 3, 0, 32'h0,
               WBUF ? 0 : 5, 4, 1'b0, 32'hCAFE_0001);
    // Read never granted: aborted after 4 REQ cycles.
    run_access("rd_no_gnt", 1'b0, 1'b1, 32'h0000_0040, 32'h0, -1, 0, 32'h0,
               5, 4, 1'b1, ERR_DATA);
    // rvalid on the timeout cycle of WAIT_R completes normally.
    run_access("rd_rv_at_to", 1'b0, 1'b1, 32'h0000_0044, 32'h0000_1111, 0, 3, 32'h55AA_33CC,
               6, 1, 1'b0, 32'h55AA_33CC);
    // rvalid never arrives: aborted in WAIT_R.
    run_access("rd_wait_to", 1'b0, 1'b1, 32'h0000_0048, 32'h0, 0, -1, 32'h0,
               6, 1, 1'b1, ERR_DATA);
    // Store and load together: one write to word 0x20, load dropped.
    run_access("we_re_both", 1'b1, 1'b1, 32'h0000_0083, 32'hA5A5_0F0F, 0, 0, 32'h0,
               WBUF ? 0 : 2, 1, 1'b0, ERR_DATA);
    // Minimum-latency read at the top word address.
    run_access("rd_min", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h0BAD_F00D,
               3, 1, 1'b0, 32'h0BAD_F00D);
    repeat (3) @(negedge clk);
    check("rdata_hold", core_rdata, 32'h0BAD_F00D);
    check("no_extra_req", exp_mem_q.size(), 0);

    // Reset during WAIT_R, then a stray rvalid.
    @(posedge clk);
    #1;
    gnt_delay = 0;
    rv_delay  = -1;
    exp_mem_q.push_back({1'b0, 30'h0000_0080, 32'h0000_0000});
    core_addr  = 32'h0000_0200;
    core_wdata = 32'h0;
    core_re    = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
        @(negedge clk);
        if (dbg_state == ST_WAIT_R) seen = 1'b1;
      end
      check("rst_mid_reached_wait_r", seen, 1'b1);
    end
    #2;
    reset   = 1'b0;
    core_re = 1'b0;
    #1;
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_mem_req", m.mem_req, 1'b0);
    check("rst_mid_rdata", core_rdata, 32'h0);
    check("rst_mid_bus_err", bus_err, 1'b0);
    check("rst_mid_mem_addr", m.mem_addr, 30'h0);
    check("rst_mid_stall", core_stall, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    inject_rv = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_rv_state", dbg_state, ST_IDLE);
      check("stray_rv_rdata", core_rdata, 32'h0);
      check("stray_rv_mem_req", m.mem_req, 1'b0);
    end
    @(posedge clk);
    #1;

    // Write after reset; load data must still be the reset value.
    run_access("wr_after_rst", 1'b1, 1'b0, 32'h0000_0300, 32'h7777_8888, 0, 0, 32'h0,
               WBUF ? 0 : 2, 1, 1'b0, 32'h0);

`ifdef MEM_BRIDGE_WBUF_EN
    // Posted write followed next cycle by a read.
    base = req_cycles;
    exp_mem_q.push_back({1'b1, 30'h0000_00C1, 32'h1357_9BDF});
    exp_done_q.push_back({1'b0, 32'h0});
    do_access(1'b1, 1'b0, 32'h0000_0304, 32'h1357_9BDF, 0, 0, 32'h0, st);
    check("wbuf_wr_stall", st, 0);
    exp_mem_q.push_back({1'b0, 30'h0000_00C2, 32'h0});
    exp_done_q.push_back({1'b0, 32'h4444_2222});
    do_access(1'b0, 1'b1, 32'h0000_0308, 32'h0, 0, 0, 32'h4444_2222, st);
    wait_idle();
    check("wbuf_rd_stall", st, 5);
    check("wbuf_req_cycles", req_cycles - base, 2);
`else
    st   = 0;
    base = 0;
`endif

    repeat (5) @(negedge clk);
    check("exp_mem_empty", exp_mem_q.size(), 0);
    check("exp_done_empty", exp_done_q.size(), 0);
    check("bus_err_pulses", err_pulses, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255: maximum wait cycles in REQ or WAIT_R before the access is aborted.
REQ-002 The module SHALL have parameter ERR_DATA, default 32'h0000_0000: read data returned on an aborted read.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 core_addr  in  32  byte address from the core ALU result; bits [1:0] are ignored.
REQ-006 core_wdata  in  32  store data from the core.
REQ-007 core_we  in  1  store request; core_re  in  1  load request.
REQ-008 core_rdata  out  32  load data to the core.
REQ-009 core_stall  out  1  freezes the core PC and register write while high.
REQ-010 mem_req  out  1  external request; mem_we  out  1  request is a write; mem_addr  out  30  word address; mem_wdata  out  32  write data.
REQ-011 mem_gnt  in  1  request accepted; mem_rvalid  in  1  read data valid; mem_rdata  in  32  read data.
REQ-012 bus_err  out  1  one-cycle pulse on an aborted access.

Function
REQ-013 The FSM SHALL have states IDLE, REQ, WAIT_R and DONE.
- IDLE to REQ on core_we|core_re, latching addr[31:2], wdata and type.
- REQ to DONE on mem_gnt&write; REQ to WAIT_R on mem_gnt&read.
- WAIT_R to DONE on mem_rvalid.
- DONE to IDLE unconditionally.
REQ-014 If core_we and core_re are both high, the access SHALL be a write and the read SHALL be dropped.
REQ-015 core_stall SHALL be combinationally high in IDLE when an access is presented, high in REQ and WAIT_R, and low in DONE and in IDLE when no access is presented.
REQ-016 mem_req SHALL be high only in REQ; mem_we, mem_addr and mem_wdata SHALL come from latched registers and stay stable while mem_req is high.
REQ-017 mem_rdata SHALL be registered on mem_rvalid in WAIT_R, and core_rdata SHALL present that register, holding it until the next captured read.
REQ-018 mem_rvalid outside WAIT_R and mem_gnt outside REQ SHALL be ignored.
REQ-019 Minimum latency SHALL be 3 cycles for a write (IDLE, REQ, DONE) and 4 cycles for a read with gnt and rvalid each arriving on their first cycle.
REQ-020 The wait counter SHALL clear on entering REQ or WAIT_R and increment each cycle in those states.
REQ-021 When the counter reaches TIMEOUT, the FSM SHALL go to DONE, pulse bus_err, and load ERR_DATA into core_rdata if the access is a read.
REQ-022 A mem_gnt or mem_rvalid arriving on the same cycle as the timeout SHALL win: the access completes normally and bus_err is not asserted.

Reset
REQ-023 On reset low, the module SHALL asynchronously enter IDLE and drive mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rdata=0, bus_err=0, counter=0 and the write-buffer-valid flag=0.
REQ-024 A reset mid-access SHALL abandon the access with no completion or error pulse, and outputs SHALL follow REQ-023 while reset is low.

Configuration
REQ-025 With MEM_BRIDGE_WBUF_EN defined, a store in IDLE with the buffer empty SHALL be posted:
- core_stall stays low;
- the store is captured into a one-entry buffer;
- the FSM goes to REQ with the buffer marked valid;
- the buffer clears on DONE.
REQ-026 With MEM_BRIDGE_WBUF_EN defined, any access presented while the buffer is valid SHALL stall until the FSM returns to IDLE, and is then handled as a new access.
REQ-027 Without MEM_BRIDGE_WBUF_EN, all stores SHALL stall per REQ-015, and no buffer logic SHALL exist.

Structure
REQ-028 Package mem_bridge_pkg SHALL hold the FSM state enum, the default TIMEOUT and the default ERR_DATA constant.
REQ-029 The wait counter SHALL be a sub-module, bus_timeout_ctr (clear, enable, count, expired).

Verification
REQ-030 Read at 0x0000_0010, gnt on the 1st REQ cycle, rvalid 2 cycles later with 0xCAFE_0001 -> mem_addr=0x4, core_rdata=0xCAFE_0001, stall high for exactly 4 cycles.
REQ-031 Write 0x1234_5678 to 0x20, gnt held off for 3 cycles -> mem_req high for 4 cycles, mem_addr=0x8, mem_wdata stable throughout, no bus_err.
REQ-032 Read with no gnt and TIMEOUT=4 -> DONE after 4 REQ cycles, bus_err pulses once, core_rdata=ERR_DATA.
REQ-033 Reset low during WAIT_R, then rvalid arrives -> mem_req=0, FSM in IDLE, rvalid ignored, core_rdata=0.
REQ-034 With MEM_BRIDGE_WBUF_EN: write followed on the next cycle by a read -> no stall on the write, stall on the read until the write's DONE, then the read completes.
REQ-035 core_we and core_re both high -> exactly one write is issued and no read occurs.
